// File: rtl/ext_stage_if.sv
// Handshake/data bundle between an ext_stage and its producer/consumer.
// master = the side issuing requests and taking results; slave = the stage.
interface ext_stage_if #(
    parameter int OUT_W  = 32,
    parameter int LANE_W = $clog2(OUT_W/8)
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        ExtSel;
    logic [OUT_W-1:0]  din;
    logic [LANE_W-1:0] lane;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  extout;
    logic              out_err;

    modport master (
        output flush, in_valid, ExtSel, din, lane, out_ready,
        input  in_ready, out_valid, extout, out_err
    );

    modport slave (
        input  flush, in_valid, ExtSel, din, lane, out_ready,
        output in_ready, out_valid, extout, out_err
    );
endinterface

// File: rtl/ext_stage.sv
// Registered immediate / sub-word load extension stage with a one-entry
// valid/ready output register and flush.
module ext_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic       CLK,
    input  logic       nRST,
    ext_stage_if.slave bus
);
    localparam int LANE_W = $clog2(OUT_W/8);

    logic [IN_W-1:0]    imm;
    logic [OUT_W-1:0]   imm_sext;
    logic [OUT_W-1:0]   imm_zext;
    logic [OUT_W-1:0]   imm_upper;
    logic [LANE_W+2:0]  byte_base;
    logic [LANE_W+2:0]  half_base;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [OUT_W-1:0]   res;
    logic               err;
    logic               accept;

    assign imm = bus.din[IN_W-1:0];

    // Replicate-then-overwrite keeps IN_W == OUT_W legal (no zero-width replication).
    always_comb begin
        imm_sext             = {OUT_W{imm[IN_W-1]}};
        imm_sext[IN_W-1:0]   = imm;
        imm_zext             = '0;
        imm_zext[IN_W-1:0]   = imm;
        imm_upper            = '0;
        imm_upper[OUT_W-1 -: IN_W] = imm;
    end

    // Halfword base is the byte base with bit 3 cleared (aligned down to 2 bytes).
    always_comb begin
        byte_base    = {bus.lane, 3'b000};
        half_base    = byte_base;
        half_base[3] = 1'b0;
        byte_v       = bus.din[byte_base +: 8];
        half_v       = bus.din[half_base +: 16];
    end

    always_comb begin
        res = '0;
        unique case (bus.ExtSel)
            3'b000: res = imm_sext;
            3'b001: res = imm_zext;
            3'b010: res = imm_upper;
            3'b011: res = imm_sext << 2;
            3'b100: res = {{(OUT_W-8){byte_v[7]}}, byte_v};
            3'b101: res = {{(OUT_W-8){1'b0}}, byte_v};
            3'b110: res = {{(OUT_W-16){half_v[15]}}, half_v};
            3'b111: res = {{(OUT_W-16){1'b0}}, half_v};
            default: res = '0;
        endcase
    end

    assign err          = (bus.ExtSel[2:1] == 2'b11) && bus.lane[0];
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.out_valid <= 1'b0;
            bus.extout    <= '0;
            bus.out_err   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.extout    <= res;
            bus.out_err   <= err;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ext_stage.sv
// Directed scoreboard bench for ext_stage (32-bit instance plus a 12->64 instance).
module tb_ext_stage;
    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ext_stage_if #(.OUT_W(32)) bus ();
    ext_stage_if #(.OUT_W(64)) bus64 ();

    ext_stage #(.IN_W(16), .OUT_W(32)) u_dut   (.CLK(CLK), .nRST(nRST), .bus(bus));
    ext_stage #(.IN_W(12), .OUT_W(64)) u_dut64 (.CLK(CLK), .nRST(nRST), .bus(bus64));

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t pend;
    logic m_ov = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] sel, input logic [31:0] d, input logic [1:0] ln,
                       input logic [31:0] exp_d, input logic exp_e);
        bus.in_valid = 1'b1;
        bus.ExtSel   = sel;
        bus.din      = d;
        bus.lane     = ln;
        pend.d       = exp_d;
        pend.e       = exp_e;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // One clock: check handshake and held result at negedge, update model, check out_valid after edge.
    task automatic step();
        logic acc;
        logic m_ir;
        @(negedge CLK);
        m_ir = !m_ov || bus.out_ready;
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, m_ir});
        if (m_ov) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                check("extout", {32'd0, bus.extout}, {32'd0, exp_q[0].d});
                check("out_err", {63'd0, bus.out_err}, {63'd0, exp_q[0].e});
            end
        end
        acc = bus.in_valid && m_ir && !bus.flush;
        if (bus.flush) exp_q.delete();
        else if (m_ov && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(pend);
        if (bus.flush)                  m_ov = 1'b0;
        else if (acc)                   m_ov = 1'b1;
        else if (m_ov && bus.out_ready) m_ov = 1'b0;
        @(posedge CLK);
        #1;
        check("out_valid", {63'd0, bus.out_valid}, {63'd0, m_ov});
    endtask

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.ExtSel = 0; bus.din = 0; bus.lane = 0; bus.out_ready = 0;
        bus64.flush = 0; bus64.in_valid = 0; bus64.ExtSel = 0; bus64.din = 0; bus64.lane = 0;
        bus64.out_ready = 0;
        pend = '0;
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_extout", {32'd0, bus.extout}, 64'd0);
        check("rst_out_err", {63'd0, bus.out_err}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst64_out_valid", {63'd0, bus64.out_valid}, 64'd0);
        check("rst64_extout", bus64.extout, 64'd0);
        #11 nRST = 1'b1;

        // Immediate modes, back-to-back
        bus.out_ready = 1;
        req(3'b000, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0); step();
        req(3'b001, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0); step();
        req(3'b010, 32'h0000_8001, 2'd0, 32'h8001_0000, 1'b0); step();
        req(3'b011, 32'h0000_8001, 2'd0, 32'hFFFE_0004, 1'b0); step();
        req(3'b000, 32'h0000_0005, 2'd3, 32'h0000_0005, 1'b0); step();
        // Sub-word load modes
        req(3'b100, 32'h80FF_7F01, 2'd1, 32'h0000_007F, 1'b0); step();
        req(3'b100, 32'h80FF_7F01, 2'd3, 32'hFFFF_FF80, 1'b0); step();
        req(3'b101, 32'h80FF_7F01, 2'd2, 32'h0000_00FF, 1'b0); step();
        req(3'b110, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF, 1'b0); step();
        req(3'b111, 32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1'b0); step();
        // Misaligned halfword, then error clears
        req(3'b110, 32'h80FF_7F01, 2'd3, 32'hFFFF_80FF, 1'b1); step();
        req(3'b001, 32'h80FF_7F01, 2'd3, 32'h0000_7F01, 1'b0); step();
        idle(); step(); step();

        // Backpressure: three stall cycles with a waiting request
        bus.out_ready = 0;
        req(3'b001, 32'h0000_1111, 2'd0, 32'h0000_1111, 1'b0); step();
        req(3'b001, 32'h0000_2222, 2'd0, 32'h0000_2222, 1'b0); step(); step(); step();
        bus.out_ready = 1; step();
        idle(); step(); step();

        // Flush with a held result and a waiting request
        bus.out_ready = 0;
        req(3'b001, 32'h0000_3333, 2'd0, 32'h0000_3333, 1'b0); step();
        req(3'b001, 32'h0000_4444, 2'd0, 32'h0000_4444, 1'b0);
        bus.flush = 1; step();
        bus.flush = 0; bus.out_ready = 1;
        req(3'b001, 32'h0000_5555, 2'd0, 32'h0000_5555, 1'b0); step();
        idle(); step();
        // Flush while empty drops the same-cycle accept
        req(3'b001, 32'h0000_6666, 2'd0, 32'h0000_6666, 1'b0);
        bus.flush = 1; step();
        bus.flush = 0; idle(); step();
        req(3'b010, 32'h0000_7777, 2'd0, 32'h7777_0000, 1'b0); step();
        idle(); step();

        // Asynchronous reset mid-stream between edges
        bus.out_ready = 0;
        req(3'b001, 32'h0000_1234, 2'd0, 32'h0000_1234, 1'b0); step();
        idle();
        #2 nRST = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_extout", {32'd0, bus.extout}, 64'd0);
        check("arst_out_err", {63'd0, bus.out_err}, 64'd0);
        check("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        m_ov = 1'b0;
        exp_q.delete();
        #1 nRST = 1'b1;
        bus.out_ready = 1;
        req(3'b000, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0); step();
        idle(); step();

        // 12 -> 64 instance
        bus64.din = 64'h0000_0000_0000_0800;
        bus64.ExtSel = 3'b000;
        bus64.out_ready = 1;
        bus64.in_valid = 1;
        @(posedge CLK);
        #1;
        bus64.in_valid = 0;
        check("p64_out_valid", {63'd0, bus64.out_valid}, 64'd1);
        check("p64_extout", bus64.extout, 64'hFFFF_FFFF_FFFF_F800);
        check("p64_out_err", {63'd0, bus64.out_err}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ext_stage.md
Name: ext_stage

Overview:
- Parametrised, registered immediate/data extension stage for the datapath. Successor to the combinational 16→32 extender.
- Adds the following over that extender:
  - generic input/output widths;
  - branch-offset mode;
  - byte/halfword lane extraction for load data;
  - misalignment flag;
  - one-entry output register with valid/ready backpressure and flush.
- Used in the decode stage (immediates) and the memory stage (sub-word load data).

Parameters:
- IN_W, 16, immediate field width. Constraint: 2 ≤ IN_W ≤ OUT_W.
- OUT_W, 32, output/data word width. Constraint: multiple of 16.
- LANE_W, $clog2(OUT_W/8), byte-lane index width (derived; not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  discard held result and any same-cycle input.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept.
- ExtSel  in  3  mode select.
- din  in  OUT_W  immediate in din[IN_W-1:0], or full load word.
- lane  in  LANE_W  byte offset for sub-word modes.
- out_valid  out  1  extout/out_err valid.
- out_ready  in  1  consumer takes result.
- extout  out  OUT_W  extended result.
- out_err  out  1  misaligned halfword access.

Behaviour:
- Reset (nRST=0, async):
  - out_valid=0, extout=0, out_err=0, held immediately regardless of CLK.
  - The first accept is possible on the first rising edge after nRST deasserts.
- in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
- Accept:
  - Condition: in_valid && in_ready && !flush.
  - On accept, the next edge loads extout/out_err and sets out_valid=1.
  - Latency 1 cycle. Throughput 1/cycle while out_ready=1.
- Drain: out_valid && out_ready with no accept → out_valid clears next edge; extout/out_err hold their last value.
- Stall: out_valid && !out_ready → registers hold unchanged; in_ready=0.
- Flush:
  - Next edge out_valid=0; any same-cycle accept is dropped.
  - extout/out_err keep their old values (don't-care while invalid).
  - Flush has priority over everything except reset.
- ExtSel modes (imm = din[IN_W-1:0]):
  - 000 sign-extend imm to OUT_W.
  - 001 zero-extend imm.
  - 010 upper: imm placed at [OUT_W-1:OUT_W-IN_W], lower bits 0.
  - 011 branch: sign-extend imm, then shift left 2; the top 2 bits are discarded (truncate to OUT_W).
  - 100 byte signed: din[8*lane+7:8*lane], sign-extended.
  - 101 byte unsigned: same byte, zero-extended.
  - 110 half signed: halfword at byte offset {lane[LANE_W-1:1],0}, sign-extended.
  - 111 half unsigned: same halfword, zero-extended.
- out_err:
  - Registered as (ExtSel[2:1]==2'b11) && lane[0].
  - Data in that case still uses the aligned-down halfword.
- lane is ignored for modes 000–011. out_err=0 for all modes other than 110/111.
- Simultaneous accept and drain in the same cycle: the new result replaces the old with out_valid staying 1 (no bubble).

Test Plan:
- Reset mid-stream:
  - Stimulus: hold out_valid=1, extout=0x0000_1234, assert nRST=0 between edges.
  - Response: out_valid=0 and extout=0 immediately; in_ready=1.
- Immediate modes, din[15:0]=0x8001, out_ready=1:
  - 000 → 0xFFFF_8001.
  - 001 → 0x0000_8001.
  - 010 → 0x8001_0000.
  - 011 → 0xFFFE_0004.
  - Each result appears one cycle after accept.
- Sub-word load modes, din=0x80FF_7F01:
  - 100, lane=1 → 0x0000_007F.
  - 100, lane=3 → 0xFFFF_FF80.
  - 101, lane=2 → 0x0000_00FF.
  - 110, lane=2 → 0xFFFF_80FF.
  - 111, lane=0 → 0x0000_7F01.
- Misaligned halfword: 110 with lane=3 → extout=0xFFFF_80FF, out_err=1. Next request with 001 → out_err=0.
- Backpressure:
  - Setup: out_ready=0 for 3 cycles with in_valid=1 continuous.
  - During the stall: first result holds, in_ready=0.
  - After out_ready rises: next request accepted the same cycle, out_valid stays 1 across the swap, no lost or duplicated result.
- Flush:
  - flush=1 in the cycle with out_valid=1, in_valid=1 → next cycle out_valid=0.
  - The flushed request never appears.
  - The following request is accepted normally.
- Parametrised instance: IN_W=12, OUT_W=64, din[11:0]=0x800, mode 000 → 0xFFFF_FFFF_FFFF_F800.
